// File: rtl/slew_limit.sv
// -----------------------------------------------------------------------------
// slew_limit
//
// Per-sample range clamp and rate (slew) limiter for a signed data stream.
// Each accepted sample (i_valid=1) produces one result one cycle later. Stage
// extra register stages can be appended to the output path. A saturating
// counter and a sticky flag record how many samples were limited.
//
// Modes (i_mode):
//   00  bypass       result = i_data
//   01  clamp        result = i_data clamped to [i_min, i_max]
//   10  clamp+slew   clamped target, then rate-limited to +/- i_step per
//                    sample relative to the previous result
//   11  hold         result = previous result; state untouched
//
// Ports:
//   i_clkp      clock, rising edge
//   i_rstn      asynchronous active-low reset
//   i_valid     sample strobe
//   i_data      signed input sample
//   i_min       signed lower limit
//   i_max       signed upper limit
//   i_step      unsigned max change per sample (0 = slew limiting off)
//   i_mode      operating mode, applied every cycle
//   i_clr       synchronous clear of o_sat_cnt and o_sticky
//   o_valid     output sample strobe (1+Stage cycles after i_valid)
//   o_data      limited output sample (holds between strobes)
//   o_sat_lo    sample clamped to i_min
//   o_sat_hi    sample clamped to i_max
//   o_slew      sample altered by slew limiting
//   o_cfg_err   sample produced with i_min > i_max in a clamp mode
//   o_sticky    OR of all limit/error events since reset or clear
//   o_sat_cnt   saturating count of limited samples
// -----------------------------------------------------------------------------
module slew_limit #(
    parameter int Width    = 32,
    parameter int Stage    = 0,
    parameter int CntWidth = 16
) (
    input  logic                i_clkp,
    input  logic                i_rstn,
    input  logic                i_valid,
    input  logic [Width-1:0]    i_data,
    input  logic [Width-1:0]    i_min,
    input  logic [Width-1:0]    i_max,
    input  logic [Width-1:0]    i_step,
    input  logic [1:0]          i_mode,
    input  logic                i_clr,
    output logic                o_valid,
    output logic [Width-1:0]    o_data,
    output logic                o_sat_lo,
    output logic                o_sat_hi,
    output logic                o_slew,
    output logic                o_cfg_err,
    output logic                o_sticky,
    output logic [CntWidth-1:0] o_sat_cnt
);

    // Two guard bits make target - y_prev and y_prev +/- step exact for any
    // Width-bit signed operands and a Width-bit unsigned step.
    localparam int XW = Width + 2;
    // Payload carried through the pipeline: {cfg_err, slew, sat_hi, sat_lo, data}
    localparam int PW = Width + 4;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_CLAMP  = 2'b01;
    localparam logic [1:0] MODE_SLEW   = 2'b10;

    logic [Width-1:0]        y_prev_reg;
    logic                    primed_reg;
    logic [Stage:0]          vld_reg;
    logic [PW-1:0]           pay_reg [0:Stage];
    logic [CntWidth-1:0]     cnt_reg;
    logic                    sticky_reg;

    logic signed [Width-1:0] data_s, min_s, max_s;

    logic [Width-1:0]        target_next;
    logic                    tgt_lo, tgt_hi, tgt_cfg;

    logic signed [XW-1:0]    tgt_x, prev_x, step_x, step_neg_x, delta_x;
    logic signed [XW-1:0]    slew_res_x;
    logic                    slew_hit;

    logic [Width-1:0]        res_next;
    logic                    lo_next, hi_next, slew_next, cfg_next;
    logic                    event_next;

    assign data_s = $signed(i_data);
    assign min_s  = $signed(i_min);
    assign max_s  = $signed(i_max);

    // ------------------------------------------------------------------
    // Clamp target. Both limits at zero means "limits not programmed".
    // ------------------------------------------------------------------
    always_comb begin
        target_next = i_data;
        tgt_lo      = 1'b0;
        tgt_hi      = 1'b0;
        tgt_cfg     = 1'b0;
        if (min_s > max_s) begin
            target_next = '0;
            tgt_cfg     = 1'b1;
        end else if (i_min == '0 && i_max == '0) begin
            target_next = i_data;
        end else if (data_s < min_s) begin
            target_next = i_min;
            tgt_lo      = 1'b1;
        end else if (data_s > max_s) begin
            target_next = i_max;
            tgt_hi      = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Slew limiter. The step is only applied when |delta| exceeds it, so
    // the result always lands between y_prev and target and therefore
    // fits back into Width bits without wrap.
    // ------------------------------------------------------------------
    assign tgt_x      = {{2{target_next[Width-1]}}, target_next};
    assign prev_x     = {{2{y_prev_reg[Width-1]}}, y_prev_reg};
    assign step_x     = {2'b00, i_step};
    assign step_neg_x = -step_x;
    assign delta_x    = tgt_x - prev_x;

    always_comb begin
        slew_res_x = tgt_x;
        slew_hit   = 1'b0;
        if (primed_reg && (i_step != '0)) begin
            if (delta_x > step_x) begin
                slew_res_x = prev_x + step_x;
                slew_hit   = 1'b1;
            end else if (delta_x < step_neg_x) begin
                slew_res_x = prev_x - step_x;
                slew_hit   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode select
    // ------------------------------------------------------------------
    always_comb begin
        res_next  = y_prev_reg;
        lo_next   = 1'b0;
        hi_next   = 1'b0;
        slew_next = 1'b0;
        cfg_next  = 1'b0;
        case (i_mode)
            MODE_BYPASS: begin
                res_next = i_data;
            end
            MODE_CLAMP: begin
                res_next = target_next;
                lo_next  = tgt_lo;
                hi_next  = tgt_hi;
                cfg_next = tgt_cfg;
            end
            MODE_SLEW: begin
                res_next  = slew_res_x[Width-1:0];
                lo_next   = tgt_lo;
                hi_next   = tgt_hi;
                cfg_next  = tgt_cfg;
                slew_next = slew_hit;
            end
            default: begin
                res_next = y_prev_reg;
            end
        endcase
    end

    assign event_next = i_valid & (lo_next | hi_next | slew_next | cfg_next);

    // ------------------------------------------------------------------
    // Result register, state, and output pipeline. Payload registers only
    // load on a valid strobe so o_data holds between samples.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            y_prev_reg <= '0;
            primed_reg <= 1'b0;
            vld_reg    <= '0;
            for (int i = 0; i <= Stage; i++) begin
                pay_reg[i] <= '0;
            end
        end else begin
            vld_reg[0] <= i_valid;
            if (i_valid) begin
                pay_reg[0] <= {cfg_next, slew_next, hi_next, lo_next, res_next};
                if (i_mode != 2'b11) begin
                    y_prev_reg <= res_next;
                    primed_reg <= 1'b1;
                end
            end
            for (int i = 1; i <= Stage; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                if (vld_reg[i-1]) begin
                    pay_reg[i] <= pay_reg[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Event counter and sticky flag; clear wins over a coincident event.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
        end else if (i_clr) begin
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
        end else if (event_next) begin
            sticky_reg <= 1'b1;
            if (cnt_reg != {CntWidth{1'b1}}) begin
                cnt_reg <= cnt_reg + CntWidth'(1);
            end
        end
    end

    assign o_valid = vld_reg[Stage];
    assign {o_cfg_err, o_slew, o_sat_hi, o_sat_lo, o_data} = pay_reg[Stage];
    assign o_sticky  = sticky_reg;
    assign o_sat_cnt = cnt_reg;

endmodule

// File: tb/tb_slew_limit.sv
// -----------------------------------------------------------------------------
// tb_slew_limit
//
// Scoreboard bench for slew_limit. Two instances: dut1 (Stage=0) carries the
// functional vectors, dut2 (Stage=2) covers reset while samples are in
// flight. Stimulus pushes hand-computed expected results into a queue per
// instance; a monitor per instance pops and compares whenever o_valid is
// seen, including the 1+Stage cycle latency.
// -----------------------------------------------------------------------------
module tb_slew_limit;

    localparam int W  = 16;
    localparam int CW = 4;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_LO   = 4'b0001;
    localparam logic [3:0] F_HI   = 4'b0010;
    localparam logic [3:0] F_SL   = 4'b0100;
    localparam logic [3:0] F_CF   = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut1 signals
    logic          rstn = 1'b1, valid = 1'b0, clr = 1'b0;
    logic [W-1:0]  data = '0, mn = '0, mx = '0, step = '0;
    logic [1:0]    mode = 2'b00;
    logic          ov, olo, ohi, osl, ocf, ost;
    logic [W-1:0]  od;
    logic [CW-1:0] ocnt;

    // dut2 signals
    logic          rstn2 = 1'b1, valid2 = 1'b0, clr2 = 1'b0;
    logic [W-1:0]  data2 = '0, mn2 = '0, mx2 = '0, step2 = '0;
    logic [1:0]    mode2 = 2'b00;
    logic          ov2, olo2, ohi2, osl2, ocf2, ost2;
    logic [W-1:0]  od2;
    logic [CW-1:0] ocnt2;

    slew_limit #(.Width(W), .Stage(0), .CntWidth(CW)) dut1 (
        .i_clkp(clk), .i_rstn(rstn), .i_valid(valid), .i_data(data),
        .i_min(mn), .i_max(mx), .i_step(step), .i_mode(mode), .i_clr(clr),
        .o_valid(ov), .o_data(od), .o_sat_lo(olo), .o_sat_hi(ohi),
        .o_slew(osl), .o_cfg_err(ocf), .o_sticky(ost), .o_sat_cnt(ocnt)
    );

    slew_limit #(.Width(W), .Stage(2), .CntWidth(CW)) dut2 (
        .i_clkp(clk), .i_rstn(rstn2), .i_valid(valid2), .i_data(data2),
        .i_min(mn2), .i_max(mx2), .i_step(step2), .i_mode(mode2), .i_clr(clr2),
        .o_valid(ov2), .o_data(od2), .o_sat_lo(olo2), .o_sat_hi(ohi2),
        .o_slew(osl2), .o_cfg_err(ocf2), .o_sticky(ost2), .o_sat_cnt(ocnt2)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic [3:0]   f;
        logic [31:0]  c;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn1 = 0;
    int n_txn2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon1
        exp_t e;
        if (ov === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut1_unexpected_output: got data 0x%0h, expected no output", od);
            end else begin
                e = q1.pop_front();
                check("dut1_data", {16'h0, od}, {16'h0, e.d});
                check("dut1_flags", {28'h0, ocf, osl, ohi, olo}, {28'h0, e.f});
                check("dut1_latency", cyc - e.c, 32'd1);
                $display("txn dut1 #%0d: data=%0d flags(cfg,slew,hi,lo)=%b cnt=%0d",
                         n_txn1, $signed(od), {ocf, osl, ohi, olo}, ocnt);
                n_txn1++;
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut2_unexpected_output: got data 0x%0h, expected no output", od2);
            end else begin
                e = q2.pop_front();
                check("dut2_data", {16'h0, od2}, {16'h0, e.d});
                check("dut2_flags", {28'h0, ocf2, osl2, ohi2, olo2}, {28'h0, e.f});
                check("dut2_latency", cyc - e.c, 32'd3);
                $display("txn dut2 #%0d: data=%0d flags(cfg,slew,hi,lo)=%b",
                         n_txn2, $signed(od2), {ocf2, osl2, ohi2, olo2});
                n_txn2++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send1(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic [W-1:0] st,
                         input logic [W-1:0] ed, input logic [3:0] ef, input logic c);
        exp_t e;
        @(negedge clk);
        mode = m; valid = 1'b1; data = d; mn = lo; mx = hi; step = st; clr = c;
        e.d = ed; e.f = ef; e.c = cyc;
        q1.push_back(e);
    endtask

    task automatic idle1(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
            clr   = 1'b0;
        end
    endtask

    task automatic pulse_clr1();
        @(negedge clk);
        valid = 1'b0;
        clr   = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
    endtask

    task automatic send2(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic [W-1:0] st,
                         input logic push, input logic [W-1:0] ed, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        mode2 = m; valid2 = 1'b1; data2 = d; mn2 = lo; mx2 = hi; step2 = st;
        if (push) begin
            e.d = ed; e.f = ef; e.c = cyc;
            q2.push_back(e);
        end
    endtask

    task automatic idle2(input int n);
        repeat (n) begin
            @(negedge clk);
            valid2 = 1'b0;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        #2;
        rstn  = 1'b0;
        rstn2 = 1'b0;
        #1;
        check("reset_o_valid", {31'h0, ov}, 32'd0);
        check("reset_o_data", {16'h0, od}, 32'd0);
        check("reset_o_sat_cnt", {28'h0, ocnt}, 32'd0);
        check("reset_o_sticky", {31'h0, ost}, 32'd0);
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        rstn2 = 1'b1;

        // Clamp: 150 -> 100 hi, -300 -> -100 lo, 42 passes
        send1(2'b01, 16'd150, -16'sd100, 16'd100, 16'd0, 16'd100, F_HI, 1'b0);
        send1(2'b01, -16'sd300, -16'sd100, 16'd100, 16'd0, -16'sd100, F_LO, 1'b0);
        send1(2'b01, 16'd42, -16'sd100, 16'd100, 16'd0, 16'd42, F_NONE, 1'b0);
        idle1(1);
        check("clamp_sat_cnt", {28'h0, ocnt}, 32'd2);
        check("clamp_sticky", {31'h0, ost}, 32'd1);
        idle1(1);
        check("idle_o_valid_low", {31'h0, ov}, 32'd0);
        check("idle_o_data_hold", {16'h0, od}, 32'd42);

        pulse_clr1();
        check("clr_sat_cnt", {28'h0, ocnt}, 32'd0);
        check("clr_sticky", {31'h0, ost}, 32'd0);

        // Mid-run reset returns outputs to zero immediately and un-primes
        @(negedge clk);
        valid = 1'b0;
        rstn  = 1'b0;
        #1;
        check("midreset_o_data", {16'h0, od}, 32'd0);
        check("midreset_o_valid", {31'h0, ov}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Slew ramp 0,50x5 with step 10
        send1(2'b10, 16'd0, -16'sd1000, 16'd1000, 16'd10, 16'd0, F_NONE, 1'b0);
        send1(2'b10, 16'd50, -16'sd1000, 16'd1000, 16'd10, 16'd10, F_SL, 1'b0);
        send1(2'b10, 16'd50, -16'sd1000, 16'd1000, 16'd10, 16'd20, F_SL, 1'b0);
        send1(2'b10, 16'd50, -16'sd1000, 16'd1000, 16'd10, 16'd30, F_SL, 1'b0);
        send1(2'b10, 16'd50, -16'sd1000, 16'd1000, 16'd10, 16'd40, F_SL, 1'b0);
        send1(2'b10, 16'd50, -16'sd1000, 16'd1000, 16'd10, 16'd50, F_NONE, 1'b0);
        idle1(1);
        check("ramp_sat_cnt", {28'h0, ocnt}, 32'd4);

        // Hold then bumpless return to slew
        send1(2'b00, 16'd30, -16'sd1000, 16'd1000, 16'd10, 16'd30, F_NONE, 1'b0);
        for (int i = 0; i < 3; i++)
            send1(2'b11, 16'd99, -16'sd1000, 16'd1000, 16'd10, 16'd30, F_NONE, 1'b0);
        send1(2'b10, 16'd99, -16'sd1000, 16'd1000, 16'd5, 16'd35, F_SL, 1'b0);
        idle1(1);

        // Inverted limits, then unset limits with the most negative value
        pulse_clr1();
        send1(2'b01, 16'd7, 16'd50, -16'sd50, 16'd0, 16'd0, F_CF, 1'b0);
        idle1(1);
        check("cfg_err_sticky", {31'h0, ost}, 32'd1);
        check("cfg_err_sat_cnt", {28'h0, ocnt}, 32'd1);
        send1(2'b01, 16'h8000, 16'd0, 16'd0, 16'd0, 16'h8000, F_NONE, 1'b0);
        idle1(1);
        check("unset_limits_no_count", {28'h0, ocnt}, 32'd1);

        // Bypass ignores limits
        send1(2'b00, 16'd1234, -16'sd100, 16'd100, 16'd0, 16'd1234, F_NONE, 1'b0);

        // Full-range slew without wrap
        send1(2'b00, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000, F_NONE, 1'b0);
        send1(2'b10, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h7FFF, F_NONE, 1'b0);
        send1(2'b00, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h8000, F_NONE, 1'b0);
        send1(2'b10, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h7FFE, F_SL, 1'b0);
        send1(2'b10, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'h8000, F_NONE, 1'b0);
        send1(2'b00, 16'd100, -16'sd1000, 16'd1000, 16'd25, 16'd100, F_NONE, 1'b0);
        send1(2'b10, -16'sd100, -16'sd1000, 16'd1000, 16'd25, 16'd75, F_SL, 1'b0);
        idle1(1);

        // Counter saturation and clear-over-event
        pulse_clr1();
        for (int i = 0; i < 20; i++)
            send1(2'b01, 16'd500, -16'sd100, 16'd100, 16'd0, 16'd100, F_HI, 1'b0);
        idle1(1);
        check("sat_cnt_saturated", {28'h0, ocnt}, 32'd15);
        check("sat_sticky", {31'h0, ost}, 32'd1);
        send1(2'b01, 16'd500, -16'sd100, 16'd100, 16'd0, 16'd100, F_HI, 1'b1);
        idle1(1);
        check("clr_over_event_cnt", {28'h0, ocnt}, 32'd0);
        check("clr_over_event_sticky", {31'h0, ost}, 32'd0);
        send1(2'b01, -16'sd500, -16'sd100, 16'd100, 16'd0, -16'sd100, F_LO, 1'b0);
        idle1(2);
        check("count_after_clr", {28'h0, ocnt}, 32'd1);

        // dut2 (Stage=2): put a value on the output, then reset mid-flight
        send2(2'b00, 16'd77, 16'd0, 16'd0, 16'd0, 1'b1, 16'd77, F_NONE);
        idle2(4);
        check("dut2_pre_reset_data", {16'h0, od2}, 32'd77);
        send2(2'b00, 16'd1, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0, F_NONE);
        send2(2'b00, 16'd2, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0, F_NONE);
        send2(2'b00, 16'd3, 16'd0, 16'd0, 16'd0, 1'b0, 16'd0, F_NONE);
        #2;
        rstn2 = 1'b0;
        #1;
        check("dut2_reset_o_valid", {31'h0, ov2}, 32'd0);
        check("dut2_reset_o_data", {16'h0, od2}, 32'd0);
        idle2(2);
        rstn2 = 1'b1;
        idle2(6);
        check("dut2_no_stray_data", {16'h0, od2}, 32'd0);
        send2(2'b10, 16'd500, -16'sd1000, 16'd1000, 16'd10, 1'b1, 16'd500, F_NONE);
        idle2(5);

        check("dut1_queue_drained", q1.size(), 32'd0);
        check("dut2_queue_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
